// File: rtl/thread_issue_unit.sv
// rtl/thread_issue_unit.sv - pops aligned thread batches, masks lanes, issues to the CGRA under retire credits
// Optional THREAD_ISSUE_PERF_EN adds saturating issue/stall performance counters.
module thread_issue_unit #(
  parameter int TID_WIDTH    = 10,
  parameter int MAX_INFLIGHT = 4,
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           unrolling_factor,
  input  logic                 gen_last,
  input  logic [TID_WIDTH:0]   fifo_data_0,
  input  logic [TID_WIDTH:0]   fifo_data_1,
  input  logic [TID_WIDTH:0]   fifo_data_2,
  input  logic [TID_WIDTH:0]   fifo_data_3,
  input  logic                 fifo_data_valid,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TID_WIDTH-1:0] out_tid_0,
  output logic [TID_WIDTH-1:0] out_tid_1,
  output logic [TID_WIDTH-1:0] out_tid_2,
  output logic [TID_WIDTH-1:0] out_tid_3,
  output logic [3:0]           out_lane_mask,
  input  logic                 retire,
  output logic [CW-1:0]        inflight_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err_retire_underflow
`ifdef THREAD_ISSUE_PERF_EN
  ,
  output logic [31:0]          perf_issued_threads,
  output logic [31:0]          perf_stall_credit,
  output logic [31:0]          perf_stall_ready
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_t;

  localparam logic [CW:0] MAX_L = MAX_INFLIGHT[CW:0];

  state_t               state, state_nxt;
  logic [TID_WIDTH:0]   fifo_ent [4];
  logic [3:0]           keep_mask;
  logic [3:0]           cap_mask;
  logic [TID_WIDTH-1:0] tid_q [4];
  logic [3:0]           mask_q;
  logic [CW-1:0]        cnt_q;
  logic [CW:0]          cnt_ext;
  logic [CW:0]          cnt_p1;
  logic                 err_q;
  logic                 credit_ok;
  logic                 hs;
  logic                 start_ok;
  logic                 pop_c;
  logic                 done_c;

  assign fifo_ent[0] = fifo_data_0;
  assign fifo_ent[1] = fifo_data_1;
  assign fifo_ent[2] = fifo_data_2;
  assign fifo_ent[3] = fifo_data_3;

  // Unrolling factor 3 is reserved and behaves like a single lane.
  always_comb begin
    case (unrolling_factor)
      2'd1:    keep_mask = 4'b0011;
      2'd2:    keep_mask = 4'b1111;
      default: keep_mask = 4'b0001;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cap_mask[i] = fifo_ent[i][TID_WIDTH] & keep_mask[i];
    end
  end

  assign cnt_ext   = {1'b0, cnt_q};
  assign cnt_p1    = cnt_ext + 1'b1;
  assign credit_ok = (cnt_ext < MAX_L) || retire;
  assign hs        = (state == S_HOLD) && out_ready;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && credit_ok) begin
          pop_c     = 1'b1;
          state_nxt = S_WAIT;
        end else if (gen_last && fifo_empty && (cnt_q == '0) && !retire) begin
          done_c    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        if (fifo_data_valid) begin
          state_nxt = (cap_mask == 4'b0000) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          // The batch being accepted consumes a credit this cycle.
          if (!fifo_empty && ((cnt_p1 < MAX_L) || retire)) begin
            pop_c     = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mask_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tid_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if ((state == S_WAIT) && fifo_data_valid) begin
        mask_q <= cap_mask;
        for (int i = 0; i < 4; i++) begin
          tid_q[i] <= cap_mask[i] ? fifo_ent[i][TID_WIDTH-1:0] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case ({hs, retire})
        2'b10:   if (cnt_ext < MAX_L) cnt_q <= cnt_q + 1'b1;
        2'b01:   if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (start_ok) begin
        err_q <= 1'b0;
      end
      if (retire && !hs && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef THREAD_ISSUE_PERF_EN
  logic [32:0] issued_sum;

  assign issued_sum = {1'b0, perf_issued_threads} + 33'($countones(mask_q));

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_issued_threads <= '0;
      perf_stall_credit   <= '0;
      perf_stall_ready    <= '0;
    end else begin
      if (hs) begin
        perf_issued_threads <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
      end
      if ((state == S_IDLE) && !fifo_empty && !credit_ok && (perf_stall_credit != 32'hFFFF_FFFF)) begin
        perf_stall_credit <= perf_stall_credit + 32'd1;
      end
      if ((state == S_HOLD) && !out_ready && (perf_stall_ready != 32'hFFFF_FFFF)) begin
        perf_stall_ready <= perf_stall_ready + 32'd1;
      end
    end
  end
`endif

  // Pop and done are combinational, so reset must gate them directly.
  assign fifo_pop             = pop_c && !rst;
  assign done                 = done_c && !rst;
  assign out_valid            = (state == S_HOLD);
  assign out_lane_mask        = out_valid ? mask_q : 4'b0000;
  assign out_tid_0            = out_valid ? tid_q[0] : '0;
  assign out_tid_1            = out_valid ? tid_q[1] : '0;
  assign out_tid_2            = out_valid ? tid_q[2] : '0;
  assign out_tid_3            = out_valid ? tid_q[3] : '0;
  assign inflight_count       = cnt_q;
  assign busy                 = ((state != S_IDLE) && (state != S_DONE)) || (cnt_q != '0);
  assign err_retire_underflow = err_q;

endmodule

// File: tb/tb_thread_issue_unit.sv
// tb/tb_thread_issue_unit.sv - randomized and directed checks of thread_issue_unit against a queue-based model
module tb_thread_issue_unit;
  localparam int TW   = 10;
  localparam int MAXI = 2;
  localparam int CW   = $clog2(MAXI + 1);

  logic          clk = 1'b0;
  logic          rst, start, gen_last, fifo_data_valid, fifo_empty, fifo_pop;
  logic          out_valid, out_ready, retire, busy, done, err;
  logic [1:0]    uf;
  logic [TW:0]   fd [4];
  logic [TW-1:0] ot [4];
  logic [3:0]    out_lane_mask;
  logic [CW-1:0] inflight_count;

  always #5 clk = ~clk;

  thread_issue_unit #(.TID_WIDTH(TW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .start(start), .unrolling_factor(uf), .gen_last(gen_last),
    .fifo_data_0(fd[0]), .fifo_data_1(fd[1]), .fifo_data_2(fd[2]), .fifo_data_3(fd[3]),
    .fifo_data_valid(fifo_data_valid), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tid_0(ot[0]), .out_tid_1(ot[1]), .out_tid_2(ot[2]), .out_tid_3(ot[3]),
    .out_lane_mask(out_lane_mask), .retire(retire), .inflight_count(inflight_count),
    .busy(busy), .done(done), .err_retire_underflow(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO entries pack lane i at [i*11 +: 11]; expected batches are {mask, tid3..tid0}.
  logic [43:0] fifo_q [$];
  logic [43:0] exp_q  [$];
  bit          pend, had_pend, chk_en;
  logic [43:0] pend_data, out_cat, prev_out, last_hs;
  int          model_cnt, cyc, last_pop_cyc, done_cnt, done_cyc, retire_cyc, hs_cnt, pop_cnt;
  bit          err_exp, prev_stall, prev_valid;
  bit          d_rst, d_start, d_ready, d_retire, d_gen_last;

  function automatic logic [43:0] expect_of(input logic [43:0] e, input int u);
    int          lanes = (u == 1) ? 2 : (u == 2) ? 4 : 1;
    logic [43:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < lanes && e[i*11+10]) begin
        r[40+i]      = 1'b1;
        r[i*10 +: 10] = e[i*11 +: 10];
      end
    end
    return r;
  endfunction

  function automatic logic [10:0] ent(input bit v, input int t);
    return {v, 10'(t)};
  endfunction

  task automatic push4(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c, input logic [10:0] d);
    fifo_q.push_back({d, c, b, a});
  endtask

  task automatic push_rand();
    logic [43:0] e;
    for (int i = 0; i < 4; i++) e[i*11 +: 11] = ent(bit'($urandom_range(0, 1)), $urandom_range(0, 1023));
    fifo_q.push_back(e);
  endtask

  task automatic tick();
    bit hs;
    @(posedge clk);
    #1;
    rst = d_rst; start = d_start; out_ready = d_ready; retire = d_retire; gen_last = d_gen_last;
    fifo_data_valid = pend;
    for (int i = 0; i < 4; i++) fd[i] = pend ? pend_data[i*11 +: 11] : 11'($urandom);
    fifo_empty = (fifo_q.size() == 0);
    had_pend = pend;
    pend = 1'b0;
    @(negedge clk);
    cyc++;
    if (!chk_en) return;
    out_cat = {out_lane_mask, ot[3], ot[2], ot[1], ot[0]};
    check("inflight", 64'(inflight_count), 64'(model_cnt));
    check("err_sticky", 64'(err), 64'(err_exp));
    if (rst) check("pop_in_rst", 64'(fifo_pop), 0);
    if (prev_stall) begin
      check("hold_valid", 64'(out_valid), 1);
      check("hold_data", 64'(out_cat), 64'(prev_out));
    end
    if (out_valid && !out_ready) check("stall_no_pop", 64'(fifo_pop), 0);
    if (out_valid && !prev_valid) check("issue_latency", 64'(cyc - last_pop_cyc), 2);
    if (fifo_pop) begin
      check("pop_credit", 64'((model_cnt < MAXI) || retire), 1);
      check("pop_not_wait", 64'(had_pend), 0);
      check("pop_nonempty", 64'(fifo_q.size() > 0), 1);
      if (!rst && fifo_q.size() > 0) begin
        pend_data = fifo_q.pop_front();
        pend = 1'b1;
        pop_cnt++;
        last_pop_cyc = cyc;
        if (expect_of(pend_data, int'(uf)) >> 40 != 0) exp_q.push_back(expect_of(pend_data, int'(uf)));
      end
    end
    hs = out_valid && out_ready;
    if (hs) begin
      hs_cnt++;
      last_hs = out_cat;
      if (exp_q.size() == 0) check("hs_unexpected", 1, 0);
      else check("batch", 64'(out_cat), 64'(exp_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_drained", 64'(model_cnt == 0 && fifo_q.size() == 0 && exp_q.size() == 0 && gen_last), 1);
    end
    if (rst) begin
      model_cnt = 0;
      err_exp = 1'b0;
      exp_q.delete();
      if (had_pend) pend = 1'b1;  // stray valid arriving after reset
    end else begin
      if (start) err_exp = 1'b0;
      if (hs && !retire) model_cnt++;
      else if (!hs && retire) begin
        if (model_cnt > 0) model_cnt--;
        else err_exp = 1'b1;
      end
      if (retire) retire_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_out   = out_cat;
    prev_valid = out_valid;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    d_ready = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      d_retire = (model_cnt > 0);
      tick();
      ok = (fifo_q.size() == 0 && exp_q.size() == 0 && !pend && model_cnt == 0 && !out_valid);
    end
    d_retire = 1'b0;
    check("drain", 64'(ok), 1);
    tick();
  endtask

  task automatic wait_hs(input string tag, input int want);
    for (int k = 0; k < 20 && hs_cnt < want; k++) tick();
    check(tag, 64'(hs_cnt), 64'(want));
  endtask

  int base;

  initial begin
    uf = 2'd0; d_rst = 1; d_start = 0; d_ready = 0; d_retire = 0; d_gen_last = 0;
    chk_en = 0; pend = 0; model_cnt = 0; err_exp = 0; prev_stall = 0; prev_valid = 0;
    cyc = 0; last_pop_cyc = -100; done_cnt = 0; hs_cnt = 0; pop_cnt = 0; last_hs = '0;
    tick();
    chk_en = 1;
    tick();
    d_rst = 0;
    check("rst_valid", 64'(out_valid), 0);
    check("rst_mask", 64'(out_lane_mask), 0);
    check("rst_tid0", 64'(ot[0]), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);

    // Four lanes with a hole in lane 2.
    uf = 2'd2; d_ready = 1;
    push4(ent(1, 5), ent(1, 6), ent(0, 0), ent(1, 8));
    wait_hs("t1_hs", hs_cnt + 1);
    check("t1_mask", 64'(last_hs[43:40]), 64'hB);
    check("t1_tids", 64'(last_hs[39:0]), {24'h0, 10'd8, 10'd0, 10'd6, 10'd5});
    tick();
    check("t1_inflight", 64'(inflight_count), 1);
    drain();

    // Single lane keeps only lane 0.
    uf = 2'd0;
    push4(ent(1, 1), ent(1, 2), ent(1, 3), ent(1, 4));
    wait_hs("t2_hs", hs_cnt + 1);
    check("t2_mask", 64'(last_hs[43:40]), 1);
    check("t2_tids", 64'(last_hs[39:0]), 64'd1);
    drain();

    // Credit limit: third batch waits for a retire.
    uf = 2'd2; base = hs_cnt;
    for (int i = 0; i < 3; i++) push4(ent(1, 10 + i), ent(1, 20 + i), ent(1, 30 + i), ent(1, 40 + i));
    for (int k = 0; k < 12; k++) tick();
    check("t3_two_hs", 64'(hs_cnt - base), 2);
    check("t3_full", 64'(inflight_count), 2);
    check("t3_no_pop", 64'(fifo_pop), 0);
    d_retire = 1;
    tick();
    d_retire = 0;
    check("t3_pop_on_retire", 64'(fifo_pop), 1);
    for (int k = 0; k < 6; k++) tick();
    check("t3_three_hs", 64'(hs_cnt - base), 3);
    check("t3_inflight", 64'(inflight_count), 2);
    drain();

    // Back-pressure in HOLD, then back-to-back pop on acceptance.
    uf = 2'd1; d_ready = 0; base = hs_cnt;
    push_rand(); push4(ent(1, 7), ent(1, 9), ent(0, 0), ent(0, 0));
    fifo_q[0][10] = 1'b1;
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    check("t4_valid", 64'(out_valid), 1);
    for (int k = 0; k < 5; k++) tick();
    d_ready = 1;
    tick();
    check("t4_hs", 64'(hs_cnt - base), 1);
    check("t4_b2b_pop", 64'(fifo_pop), 1);
    drain();

    // Completion waits for the last retire.
    uf = 2'd0; d_gen_last = 1; done_cnt = 0;
    push4(ent(1, 3), ent(0, 0), ent(0, 0), ent(0, 0));
    for (int k = 0; k < 10 && !(model_cnt == 1 && !out_valid && fifo_q.size() == 0); k++) tick();
    for (int k = 0; k < 5; k++) tick();
    check("t5_no_early_done", 64'(done_cnt), 0);
    d_retire = 1;
    tick();
    d_retire = 0;
    for (int k = 0; k < 5; k++) tick();
    check("t5_done_once", 64'(done_cnt), 1);
    check("t5_done_time", 64'(done_cyc - retire_cyc), 1);
    check("t5_idle", 64'(busy), 0);
    d_start = 1; d_gen_last = 0;
    tick();
    d_start = 0;
    base = hs_cnt;
    push_rand(); fifo_q[0][10] = 1'b1;
    wait_hs("t5_restart", base + 1);
    drain();

    // Retire underflow is sticky until start.
    d_retire = 1;
    tick();
    d_retire = 0;
    for (int k = 0; k < 3; k++) tick();
    check("t6_err", 64'(err), 1);
    check("t6_cnt", 64'(inflight_count), 0);
    d_start = 1;
    tick();
    d_start = 0;
    tick();
    check("t6_err_clr", 64'(err), 0);

    // Reset while waiting for pop data.
    uf = 2'd2; base = pop_cnt;
    push_rand(); fifo_q[0][10] = 1'b1;
    for (int k = 0; k < 10 && pop_cnt == base; k++) tick();
    check("t7_popped", 64'(pop_cnt - base), 1);
    d_rst = 1;
    tick();
    d_rst = 0;
    tick();
    check("t7_valid", 64'(out_valid), 0);
    check("t7_mask", 64'(out_lane_mask), 0);
    tick();
    check("t7_no_late_cap", 64'(out_valid), 0);

    // Randomized traffic for every unrolling factor.
    for (int u = 0; u < 4; u++) begin
      uf = 2'(u);
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 2) == 0) push_rand();
        d_ready  = ($urandom_range(0, 9) < 7);
        d_retire = (model_cnt > 0) && ($urandom_range(0, 9) < 3);
        tick();
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/thread_issue_unit.md
Name: thread_issue_unit

Overview:
- Downstream consumer of the thread filter's four per-lane {valid, tid} FIFOs.
- Pops one aligned batch at a time and applies the unrolling-factor lane mask.
- Presents the batch to the CGRA issue port over a valid/ready handshake.
- Limits outstanding batches with a retire-driven credit counter and signals kernel completion once everything is drained and retired.

Parameters:
TID_WIDTH, 10, thread-id width; FIFO entry width is TID_WIDTH+1 ({valid, tid})
MAX_INFLIGHT, 4, max batches issued to CGRA and not yet retired (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  kernel start pulse; honoured only in IDLE or DONE
unrolling_factor  in  2  0=1 lane, 1=2 lanes, 2=4 lanes; 3 treated as 0
gen_last  in  1  level; upstream has generated every thread of the kernel
fifo_data_0..fifo_data_3  in  TID_WIDTH+1 each  head entries {valid, tid}
fifo_data_valid  in  1  pop data valid, exactly 1 cycle after fifo_pop
fifo_empty  in  1  all FIFOs empty
fifo_pop  out  1  single-cycle pop request (combinational from state)
out_valid  out  1  batch valid to CGRA
out_ready  in  1  CGRA accepts batch
out_tid_0..out_tid_3  out  TID_WIDTH each  issued thread ids, 0 when lane invalid
out_lane_mask  out  4  per-lane valid bits
retire  in  1  one batch completed in CGRA
inflight_count  out  $clog2(MAX_INFLIGHT+1)  outstanding batches
busy  out  1  state != IDLE && state != DONE, or inflight_count != 0
done  out  1  single-cycle completion pulse
err_retire_underflow  out  1  sticky; retire seen with inflight_count==0

Behaviour:
- Reset: state=IDLE; fifo_pop, out_valid, done, err_retire_underflow=0; out_tid_*=0; out_lane_mask=0; inflight_count=0. Reset mid-operation discards any captured batch and does not pop.
- Lane mask: lane i is kept iff i < (1<<uf), where uf=unrolling_factor (3 counts as 0). Masked lanes force mask bit=0 and tid=0.
- credit_ok = (inflight_count < MAX_INFLIGHT) || retire.
- IDLE:
  - !fifo_empty && credit_ok -> fifo_pop=1, go WAIT.
  - Else if gen_last && fifo_empty && inflight_count==0 && !retire -> done=1 for that cycle, go DONE.
- WAIT: fifo_pop=0.
  - On fifo_data_valid, capture masked entries.
  - Masked lane_mask==0 (bubble batch) -> discard, no credit used, go IDLE.
  - Else out_valid=1, go HOLD.
  - fifo_data_valid never arriving holds WAIT indefinitely; no timeout.
- HOLD:
  - out_valid, tids and mask stay stable until out_valid && out_ready.
  - On handshake, inflight_count increments.
  - If !fifo_empty && (inflight_count+1 < MAX_INFLIGHT || retire), pop in the same cycle and go WAIT; otherwise go IDLE.
  - Sustained throughput is 1 batch per 2 cycles.
- DONE: outputs idle. start -> IDLE, clears err_retire_underflow. start in any other state is ignored.
- Counter update per cycle: +1 on handshake, -1 on retire. Both in the same cycle leave it unchanged. Retire at 0 is ignored and sets the sticky error bit. Never exceeds MAX_INFLIGHT.
- fifo_pop never asserts in WAIT, DONE, or during rst.

Optional Feature:
THREAD_ISSUE_PERF_EN
- Defined: adds outputs perf_issued_threads (32 bits, += popcount(out_lane_mask) per handshake), perf_stall_credit (32 bits, cycles in IDLE with !fifo_empty && !credit_ok), and perf_stall_ready (32 bits, cycles in HOLD with !out_ready). All are cleared by rst and by accepted start, and saturate at all-ones.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- uf=2, FIFO heads {1,5},{1,6},{0,0},{1,8}, out_ready=1 -> fifo_pop at cycle t; out_valid at t+2 with mask=4'b1011, tids 5,6,0,8; inflight_count=1.
- uf=0, heads valid in all lanes tids 1,2,3,4 -> mask=4'b0001, out_tid_0=1, others 0.
- MAX_INFLIGHT=2, 3 batches queued, no retire -> 2 handshakes then fifo_pop stays low. One retire -> pop in that same cycle, third batch issues, inflight_count stays 2.
- out_ready low for 5 cycles in HOLD -> out_valid and data stable all 5 cycles, no pop; ready high -> handshake, back-to-back pop next batch.
- gen_last=1, FIFO drained, 1 inflight -> no done; retire -> done pulse exactly 1 cycle the cycle after counter reaches 0, state DONE; start -> IDLE.
- retire with inflight_count=0 -> counter stays 0, err_retire_underflow=1 until start; rst asserted in WAIT -> next cycle all outputs at reset values, no capture of late fifo_data_valid.
